serial_mag_comparator: RTL and testbench
========================================

# serial_mag_comparator

Bit-serial unsigned magnitude comparator. It accepts two WIDTH-bit operands through a valid/ready handshake and walks them MSB-first, one bit per clock, through a single 1-bit compare cell. It returns a one-hot gt/lt/eq result through a second valid/ready handshake. It is the sequential consumer of the 1-bit compare primitive and is used where area matters more than latency.

## Interface
- WIDTH, 8, operand width in bits; legal range is WIDTH >= 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  unsigned operand A.
- b  input  WIDTH  unsigned operand B.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- gt  output  1  A > B.
- lt  output  1  A < B.
- eq  output  1  A == B.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, capture a/b into shift registers, load the bit counter with WIDTH, clear the decided flag, go to SHIFT.
  - SHIFT: each cycle, compare the current MSBs of the A and B shift registers in the 1-bit cell, shift both left by one, decrement the counter.
    - On the first cycle whose cell gives gt or lt, latch that result and set decided. Later bits are ignored.
    - When the counter reaches 0, go to DONE. If decided was never set, latch eq=1.
  - DONE: out_valid=1. gt/lt/eq are held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- Operands are captured at accept. Changes on a/b after accept are ignored.
- When out_valid=1, exactly one of gt/lt/eq is high. When out_valid=0, all three are 0.
- No bypass from DONE to a new accept: in_ready rises the cycle after the output handshake.
- Counter width is $clog2(WIDTH+1). Arithmetic is unsigned; there is no wrap because the counter stops at 0.
- rst_n asserted in any state, including mid-SHIFT or while DONE is stalled: the in-flight compare is discarded and the block returns to IDLE.

## Timing
- Reset values: in_ready=1, out_valid=0, gt=0, lt=0, eq=0. State=IDLE, counter=0, shift registers=0.
- Accept on edge k (default build): SHIFT occupies cycles k+1..k+WIDTH, and out_valid rises after edge k+WIDTH.
- With early exit (see Configuration): if the first differing bit is at index i, out_valid rises after edge k+(WIDTH-i). Equal operands always take WIDTH cycles.
- Worst-case throughput: one compare per WIDTH+2 cycles, with out_ready held high.
- out_ready low in DONE: the block stalls indefinitely, outputs are stable, and in_ready stays 0.
- in_valid is sampled only in IDLE. The block has no combinational path from in_valid or out_ready to any output.

## Configuration
- SERCMP_EARLY_EXIT_EN defined: SHIFT exits to DONE on the cycle the first differing bit is found, so latency depends on the data.
- Not defined: SHIFT always runs the full WIDTH cycles, so latency is fixed. gt/lt/eq results are identical in both builds.

## Structure
- Shared package sercmp_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the one-hot result encoding localparams (RES_GT, RES_LT, RES_EQ).
- One sub-module, cmp_bit_cell: a combinational 1-bit compare with gt = a&~b, lt = ~a&b, eq = ~(gt|lt). It is instantiated once.

## Test plan
- Reset then idle, WIDTH=8: in_ready=1, out_valid=0, gt/lt/eq=0. Assert rst_n low mid-SHIFT → IDLE next edge, out_valid=0.
- a=0xA5, b=0xA5, out_ready=1 → eq=1, out_valid after exactly 8 SHIFT cycles in both builds.
- a=0x80, b=0x7F → gt=1. Early-exit build: out_valid 1 cycle after accept. Default build: 8 cycles.
- a=0x12, b=0x13 → lt=1, decided on bit 0, 8 cycles in both builds.
- a=0xFF, b=0x00 with out_ready held low for 5 cycles → gt=1 stable, in_ready=0 throughout. Release out_ready → in_ready=1 the next cycle.
- Back-to-back: (0x01, 0x02) then (0xFE, 0xFE) with a/b changed during SHIFT → results lt then eq. Mid-operation input changes have no effect.

Source files
------------

// File: rtl/sercmp_pkg.sv
// ---------------------------------------------------------------------------
// sercmp_pkg
// Shared definitions for the bit-serial magnitude comparator.
//   state_t  : FSM state encoding (IDLE, SHIFT, DONE)
//   RES_*    : one-hot result encoding, bit order {gt, lt, eq}
//   res_of   : packs separate gt/lt/eq flags into the one-hot encoding
// ---------------------------------------------------------------------------
package sercmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_LT = 3'b010;
  localparam logic [2:0] RES_EQ = 3'b001;

  function automatic logic [2:0] res_of(input logic gt, input logic lt, input logic eq);
    return {gt, lt, eq};
  endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// ---------------------------------------------------------------------------
// cmp_bit_cell
// Combinational 1-bit unsigned compare primitive. Exactly one output is high.
// Ports:
//   a, b : input bits
//   gt   : a > b  (a & ~b)
//   lt   : a < b  (~a & b)
//   eq   : a == b
// ---------------------------------------------------------------------------
module cmp_bit_cell (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt,
  output logic eq
);

  assign gt = a & ~b;
  assign lt = ~a & b;
  assign eq = ~(gt | lt);

endmodule

// File: rtl/serial_mag_comparator.sv
// ---------------------------------------------------------------------------
// serial_mag_comparator
// Bit-serial unsigned magnitude comparator. Operands are captured on the input
// handshake and walked MSB-first through one cmp_bit_cell, one bit per clock.
// The one-hot gt/lt/eq result is offered on the output handshake.
//
// Handshakes: a transfer happens on a rising edge where valid && ready. Both
// ready (in_ready) and valid (out_valid) are registered; there is no
// combinational path from in_valid or out_ready to any output. in_valid is
// only looked at in IDLE; the result is held stable in DONE until out_ready.
//
// Configuration macro: SERCMP_EARLY_EXIT_EN
//   defined     : SHIFT ends on the first differing bit (data-dependent latency)
//   not defined : SHIFT always runs WIDTH cycles (fixed latency)
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake, a/b captured on transfer
//   a, b                : WIDTH-bit unsigned operands
//   out_valid/out_ready : result handshake
//   gt, lt, eq          : one-hot result, all zero while out_valid is low
// ---------------------------------------------------------------------------
module serial_mag_comparator
  import sercmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // FSM state kept as a plain named signal so checkers can bind to it.
  state_t             state;
  logic [WIDTH-1:0]   sh_a;
  logic [WIDTH-1:0]   sh_b;
  logic [CNT_W-1:0]   cnt;
  logic               decided;
  logic [2:0]         res;

  logic               cell_gt;
  logic               cell_lt;
  logic               cell_eq;
  logic [2:0]         cell_res;
  logic [2:0]         res_next;
  logic               last_bit;
  logic               finish;

  cmp_bit_cell u_cell (
    .a  (sh_a[WIDTH-1]),
    .b  (sh_b[WIDTH-1]),
    .gt (cell_gt),
    .lt (cell_lt),
    .eq (cell_eq)
  );

  assign cell_res = res_of(cell_gt, cell_lt, cell_eq);

  // The first decisive bit wins; once decided, later bits are ignored.
  // An undecided walk leaves the cell's eq result, which is RES_EQ on
  // the final bit when every bit matched.
  assign res_next = decided ? res : cell_res;
  assign last_bit = (cnt == CNT_W'(1));

`ifdef SERCMP_EARLY_EXIT_EN
  assign finish = last_bit || (!decided && !cell_eq);
`else
  assign finish = last_bit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh_a      <= '0;
      sh_b      <= '0;
      cnt       <= '0;
      decided   <= 1'b0;
      res       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a     <= a;
            sh_b     <= b;
            cnt      <= CNT_W'(WIDTH);
            decided  <= 1'b0;
            res      <= RES_EQ;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          sh_a <= sh_a << 1;
          sh_b <= sh_b << 1;
          cnt  <= cnt - CNT_W'(1);
          if (!decided && !cell_eq) begin
            res     <= cell_res;
            decided <= 1'b1;
          end
          if (finish) begin
            cnt          <= '0;
            out_valid    <= 1'b1;
            {gt, lt, eq} <= res_next;
            state        <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// ---------------------------------------------------------------------------
// tb_serial_mag_comparator
// Directed and randomized checks of serial_mag_comparator (WIDTH = 8).
// Expected results come from plain integer comparison of the operands; the
// expected latency comes from the position of the highest differing bit.
// ---------------------------------------------------------------------------
module tb_serial_mag_comparator;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic         gt;
  logic         lt;
  logic         eq;

  int n_assert = 0;
  int n_fail   = 0;

  logic [2:0] exp_q[$];

  serial_mag_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [2:0] model_res(input logic [W-1:0] av, input logic [W-1:0] bv);
    int unsigned ia;
    int unsigned ib;
    ia = av;
    ib = bv;
    if (ia > ib)      return 3'b100;
    else if (ia < ib) return 3'b010;
    else              return 3'b001;
  endfunction

  function automatic int model_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef SERCMP_EARLY_EXIT_EN
    logic [W-1:0] d;
    d = av ^ bv;
    for (int i = W - 1; i >= 0; i--) begin
      if (d[i]) return W - i;
    end
    return W;
`else
    return W;
`endif
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver ----------------
  // One full compare: offer operands, optionally scramble a/b after accept,
  // measure latency, hold out_ready low for 'stall' cycles, then release.
  task automatic do_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int stall, input bit scramble);
    int cycles;
    int lat;
    logic [2:0] exp_r;
    logic [2:0] held;
    lat = model_lat(av, bv);
    exp_q.push_back(model_res(av, bv));

    @(negedge clk);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    out_ready = (stall == 0);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (scramble) begin
      a = W'($urandom);
      b = W'($urandom);
    end
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);

    cycles = 0;
    while (!out_valid && cycles < W + 4) begin
      @(negedge clk);
      cycles++;
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
      end
    end
    exp_r = exp_q.pop_front();
    check("out_valid_rise", {31'd0, out_valid}, 32'd1);
    check("latency", cycles, lat);
    check("result", {29'd0, gt, lt, eq}, {29'd0, exp_r});
    held = {gt, lt, eq};

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_result", {29'd0, gt, lt, eq}, {29'd0, held});
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("post_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_result_zero", {29'd0, gt, lt, eq}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {29'd0, gt, lt, eq}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // Directed cases
    do_cmp(8'hA5, 8'hA5, 0, 1'b0);
    do_cmp(8'h80, 8'h7F, 0, 1'b0);
    do_cmp(8'h12, 8'h13, 0, 1'b0);
    do_cmp(8'hFF, 8'h00, 5, 1'b0);
    do_cmp(8'h01, 8'h02, 0, 1'b1);
    do_cmp(8'hFE, 8'hFE, 0, 1'b1);
    do_cmp(8'h00, 8'h00, 1, 1'b0);
    do_cmp(8'h00, 8'h01, 0, 1'b0);
    do_cmp(8'hFF, 8'hFE, 2, 1'b1);

    // Reset in the middle of SHIFT (equal operands always stay in SHIFT W cycles)
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'h3C;
    b = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midshift_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midshift_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    check("midshift_no_result", {31'd0, out_valid}, 32'd0);
    check("midshift_idle_ready", {31'd0, in_ready}, 32'd1);

    // Reset while DONE is stalled
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    a = 8'h10;
    b = 8'h20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("stalled_out_valid", {31'd0, out_valid}, 32'd1);
    check("stalled_result", {29'd0, gt, lt, eq}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("done_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("done_rst_result", {29'd0, gt, lt, eq}, 32'd0);
    check("done_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Random compares, biased toward near-equal operands
    for (int t = 0; t < 30; t++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      if ($urandom_range(0, 2) == 0) rb = ra;
      else if ($urandom_range(0, 1) == 0) rb = ra ^ W'(1 << $urandom_range(0, W - 1));
      else rb = W'($urandom);
      do_cmp(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
